pkt_filter_ctrl: RTL and testbench

PKT_FILTER_CTRL -- requirements
Module: pkt_filter_ctrl

---
 rtl/pkt_filter_pkg.sv | 7 +
 rtl/pkt_filter_ctrl_hdr_capture_buf.sv | 42 ++++
 rtl/pkt_filter_ctrl.sv | 118 +++++++++++
 tb/tb_pkt_filter_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_filter_pkg.sv
// pkt_filter_pkg: shared types and widths for the packet filter controller.
package pkt_filter_pkg;
    localparam int HDR_BYTES   = 64;
    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    typedef enum logic [2:0] {IDLE, CAPTURE, DECIDE, REPLAY, PASS, DROP} state_t;
endpackage

// File: rtl/pkt_filter_ctrl_hdr_capture_buf.sv
// hdr_capture_buf: per-beat header storage with replay read port and byte-mapped header view.
module hdr_capture_buf
    import pkt_filter_pkg::*;
#(
    parameter int HDR_BEATS = 8,
    parameter int IW        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_idx,
    input  logic [AXIS_DATA_W-1:0] wr_data,
    input  logic [AXIS_KEEP_W-1:0] wr_keep,
    input  logic [IW-1:0]          rd_idx,
    output logic [AXIS_DATA_W-1:0] rd_data,
    output logic [AXIS_KEEP_W-1:0] rd_keep,
    output logic [0:HDR_BYTES*8-1] hdr_data
);
    logic [AXIS_DATA_W-1:0] data_mem [HDR_BEATS];
    logic [AXIS_KEEP_W-1:0] keep_mem [HDR_BEATS];
    // Clearing keep alone is enough to zero uncaptured bytes in the header view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < HDR_BEATS; k++) keep_mem[k] <= '0;
        end else begin
            for (int k = 0; k < HDR_BEATS; k++) if (clr) keep_mem[k] <= '0;
            if (wr_en) keep_mem[wr_idx] <= wr_keep;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[wr_idx] <= wr_data;
    end
    assign rd_data = data_mem[rd_idx];
    assign rd_keep = keep_mem[rd_idx];
    always_comb begin
        hdr_data = '0;
        for (int k = 0; k < HDR_BEATS; k++)
            for (int j = 0; j < AXIS_KEEP_W; j++)
                hdr_data[(k*AXIS_KEEP_W+j)*8 +: 8] = keep_mem[k][j] ? data_mem[k][j*8 +: 8] : 8'h00;
    end
endmodule

// File: rtl/pkt_filter_ctrl.sv
// pkt_filter_ctrl: captures packet header, applies external filter verdict, replays or drops.
// Packet counters exist only when PKT_FILTER_CTRL_STATS_EN is defined.
module pkt_filter_ctrl
    import pkt_filter_pkg::*;
#(
    parameter int HDR_BEATS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [63:0]   s_tdata,
    input  logic [7:0]    s_tkeep,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [63:0]   m_tdata,
    output logic [7:0]    m_tkeep,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [0:511]  hdr_data,
    input  logic          filters_valid,
    output logic [31:0]   pass_cnt,
    output logic [31:0]   drop_cnt
);
    localparam int IW = HDR_BEATS > 1 ? $clog2(HDR_BEATS) : 1;
    localparam logic [IW-1:0] LAST_BEAT = IW'(HDR_BEATS - 1);
    state_t state, state_nx;
    logic [IW-1:0] wr_idx, rd_idx, last_idx, cur_idx;
    logic [63:0] rd_data;
    logic [7:0] rd_keep;
    logic last_seen, wr_en, clr, rd_last, rdy;
    assign cur_idx = (state == IDLE) ? '0 : wr_idx;
    assign rd_last = rd_idx == last_idx;
    hdr_capture_buf #(.HDR_BEATS(HDR_BEATS), .IW(IW)) u_buf (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(cur_idx),
        .wr_data(s_tdata), .wr_keep(s_tkeep), .rd_idx(rd_idx),
        .rd_data(rd_data), .rd_keep(rd_keep), .hdr_data(hdr_data)
    );
    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        clr      = 1'b0;
        rdy      = 1'b0;
        m_tvalid = 1'b0;
        m_tdata  = rd_data;
        m_tkeep  = rd_keep;
        m_tlast  = 1'b0;
        case (state)
            IDLE: begin
                rdy   = 1'b1;
                wr_en = s_tvalid;
                clr   = s_tvalid;
                if (s_tvalid) state_nx = (s_tlast || HDR_BEATS == 1) ? DECIDE : CAPTURE;
            end
            CAPTURE: begin
                rdy   = 1'b1;
                wr_en = s_tvalid;
                if (s_tvalid && (s_tlast || wr_idx == LAST_BEAT)) state_nx = DECIDE;
            end
            DECIDE: state_nx = filters_valid ? REPLAY : (last_seen ? IDLE : DROP);
            REPLAY: begin
                m_tvalid = 1'b1;
                m_tlast  = last_seen && rd_last;
                if (m_tready && rd_last) state_nx = last_seen ? IDLE : PASS;
            end
            PASS: begin
                m_tvalid = s_tvalid;
                m_tdata  = s_tdata;
                m_tkeep  = s_tkeep;
                m_tlast  = s_tlast;
                rdy      = m_tready;
                if (s_tvalid && m_tready && s_tlast) state_nx = IDLE;
            end
            DROP: begin
                rdy = 1'b1;
                if (s_tvalid && s_tlast) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Ready must drop the instant reset asserts, not one edge later
    assign s_tready = rdy & rst_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            last_idx  <= '0;
            last_seen <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr_en) begin
                wr_idx    <= cur_idx + 1'b1;
                last_idx  <= cur_idx;
                last_seen <= s_tlast;
            end
            if (state == DECIDE) rd_idx <= '0;
            else if (state == REPLAY && m_tready) rd_idx <= rd_idx + 1'b1;
        end
    end
`ifdef PKT_FILTER_CTRL_STATS_EN
    logic [31:0] pass_q, drop_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= '0;
            drop_q <= '0;
        end else if (state == DECIDE) begin
            if (filters_valid) pass_q <= pass_q + 1'b1;
            else drop_q <= drop_q + 1'b1;
        end
    end
    assign pass_cnt = pass_q;
    assign drop_cnt = drop_q;
`else
    assign pass_cnt = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_filter_ctrl.sv
// tb_pkt_filter_ctrl: randomized packets checked against a packet-level reference model.
module tb_pkt_filter_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [63:0] s_tdata = '0, m_tdata;
    logic [7:0] s_tkeep = '0, m_tkeep;
    logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic m_tvalid, m_tlast, m_tready;
    logic [0:511] hdr_data;
    logic filters_valid = 1'b0;
    logic [31:0] pass_cnt, drop_cnt;

    typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
    beat_t exp_q[$], act_q[$];
    beat_t prev_b;
    logic prev_stall = 1'b0;
    int vecs = 0, errs = 0, exp_pass = 0, exp_drop = 0, rmode = 0, waits = 0;
    int stats = 0;
    logic [0:511] exp_hdr, hdr_snap;
    logic [3:0] pat = 4'b1001;

    always #5 clk = ~clk;

    pkt_filter_ctrl #(.HDR_BEATS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .hdr_data(hdr_data), .filters_valid(filters_valid), .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
    );

    initial begin
        int pc = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom_range(0, 9) < 7) : pat[pc % 4];
            pc++;
        end
    end

    // Egress monitor: collects accepted beats and checks that stalled beats are held
    initial forever begin
        @(negedge clk);
        if (rst_n && prev_stall) begin
            vecs++;
            if (!m_tvalid || {m_tdata, m_tkeep, m_tlast} !== prev_b) begin
                errs++;
                $display("FAIL stall_hold: got v=%b %h/%h/%b required v=1 %h/%h/%b", m_tvalid, m_tdata, m_tkeep, m_tlast, prev_b.d, prev_b.k, prev_b.l);
            end
        end
        if (rst_n && m_tvalid && m_tready) act_q.push_back({m_tdata, m_tkeep, m_tlast});
        prev_stall = rst_n && m_tvalid && !m_tready;
        prev_b = {m_tdata, m_tkeep, m_tlast};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input beat_t b, input int gap);
        logic rdy;
        s_tvalid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l; s_tvalid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
            if (t > 500) begin
                vecs++; errs++;
                $display("FAIL ingress_timeout: s_tready stuck at %b, required 1", s_tready);
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit pass, input int maxgap, input logic [7:0] lastkeep);
        beat_t b;
        filters_valid = pass;
        exp_hdr = '0;
        if (pass) exp_pass++; else exp_drop++;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            b.k = (i == n - 1) ? (lastkeep != 0 ? lastkeep : 8'($urandom_range(1, 255))) : 8'hFF;
            b.l = (i == n - 1);
            if (i < 8) for (int j = 0; j < 8; j++) if (b.k[j]) exp_hdr[(8*i+j)*8 +: 8] = b.d[8*j +: 8];
            if (pass) exp_q.push_back(b);
            send_beat(b, maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic drain(output bit to);
        int t = 0;
        while (act_q.size() < exp_q.size() && t < 400) begin @(posedge clk); #1; t++; end
        repeat (3) begin @(posedge clk); #1; end
        to = (t >= 400);
    endtask

    function automatic int sb_diff();
        int d = (act_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) if (act_q[i] !== exp_q[i]) d++;
        act_q.delete();
        exp_q.delete();
        return d;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++; if (s_tready !== 1'b0) begin errs++; $display("FAIL reset_s_tready: got %b required 0", s_tready); end
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL reset_m_tvalid: got %b required 0", m_tvalid); end
        vecs++; if (hdr_data !== '0) begin errs++; $display("FAIL reset_hdr: got %h required 0", hdr_data); end
        vecs++; if (pass_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", pass_cnt, drop_cnt); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        vecs++; if (s_tready !== 1'b1) begin errs++; $display("FAIL release_s_tready: got %b required 1", s_tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_pass_10();
        bit to; int d, n;
        rmode = 0;
        send_pkt(10, 1, 0, 8'hFF);
        drain(to);
        n = act_q.size();
        d = sb_diff();
        vecs++; if (to) begin errs++; $display("FAIL pass10_drain: timeout got %0d beats required 10", n); end
        vecs++; if (n !== 10 || d !== 0) begin errs++; $display("FAIL pass10_egress: got %0d beats %0d diffs required 10 beats 0 diffs", n, d); end
        vecs++; if (hdr_data !== exp_hdr) begin errs++; $display("FAIL pass10_hdr: got %h required %h", hdr_data, exp_hdr); end
        vecs++; if (pass_cnt !== 32'(stats * exp_pass) || drop_cnt !== 32'(stats * exp_drop)) begin errs++; $display("FAIL pass10_cnt: got %0d/%0d required %0d/%0d", pass_cnt, drop_cnt, stats * exp_pass, stats * exp_drop); end
    endtask

    task automatic test_drop_10();
        bit to; int d, n;
        rmode = 0;
        waits = 0;
        send_pkt(10, 0, 0, 8'hFF);
        vecs++; if (waits !== 1) begin errs++; $display("FAIL drop10_ready: got %0d stall cycles required 1", waits); end
        drain(to);
        n = act_q.size();
        d = sb_diff();
        vecs++; if (to || n !== 0 || d !== 0) begin errs++; $display("FAIL drop10_egress: got %0d beats required 0", n); end
        vecs++; if (pass_cnt !== 32'(stats * exp_pass) || drop_cnt !== 32'(stats * exp_drop)) begin errs++; $display("FAIL drop10_cnt: got %0d/%0d required %0d/%0d", pass_cnt, drop_cnt, stats * exp_pass, stats * exp_drop); end
    endtask

    task automatic test_short_3();
        bit to; int d, n; beat_t lastb;
        rmode = 0;
        send_pkt(3, 1, 0, 8'h0F);
        drain(to);
        n = act_q.size();
        lastb = (n > 0) ? act_q[n-1] : '0;
        d = sb_diff();
        hdr_snap = hdr_data;
        vecs++; if (hdr_snap[160:511] !== '0) begin errs++; $display("FAIL short3_hdr_tail: got %h required 0", hdr_snap[160:511]); end
        vecs++; if (hdr_snap !== exp_hdr) begin errs++; $display("FAIL short3_hdr: got %h required %h", hdr_snap, exp_hdr); end
        vecs++; if (to || n !== 3 || d !== 0 || lastb.k !== 8'h0F || lastb.l !== 1'b1) begin errs++; $display("FAIL short3_egress: got %0d beats %0d diffs keep %h last %b required 3/0/0f/1", n, d, lastb.k, lastb.l); end
        @(negedge clk);
        vecs++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin errs++; $display("FAIL short3_idle: got rdy=%b vld=%b required 1/0", s_tready, m_tvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit to; int d, n;
        rmode = 2;
        send_pkt(10, 1, 0, 8'hFF);
        drain(to);
        n = act_q.size();
        d = sb_diff();
        rmode = 0;
        vecs++; if (to || n !== 10 || d !== 0) begin errs++; $display("FAIL stall_egress: got %0d beats %0d diffs required 10/0", n, d); end
    endtask

    task automatic test_reset_mid();
        bit to; int d, n; beat_t b;
        rmode = 0;
        filters_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin b = {{$urandom, $urandom}, 8'hFF, 1'b0}; send_beat(b, 0); end
        s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
        @(negedge clk); #2; rst_n = 1'b0; #1;
        vecs++; if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin errs++; $display("FAIL midrst_hs: got rdy=%b vld=%b required 0/0", s_tready, m_tvalid); end
        vecs++; if (hdr_data !== '0) begin errs++; $display("FAIL midrst_hdr: got %h required 0", hdr_data); end
        vecs++; if (pass_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errs++; $display("FAIL midrst_cnt: got %0d/%0d required 0/0", pass_cnt, drop_cnt); end
        s_tvalid = 1'b0;
        exp_pass = 0; exp_drop = 0;
        act_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(negedge clk);
        vecs++; if (s_tready !== 1'b1) begin errs++; $display("FAIL midrst_release: got %b required 1", s_tready); end
        @(posedge clk); #1;
        send_pkt(5, 1, 0, 8'h00);
        drain(to);
        n = act_q.size();
        d = sb_diff();
        vecs++; if (to || n !== 5 || d !== 0) begin errs++; $display("FAIL midrst_next: got %0d beats %0d diffs required 5/0", n, d); end
        vecs++; if (hdr_data !== exp_hdr) begin errs++; $display("FAIL midrst_hdr2: got %h required %h", hdr_data, exp_hdr); end
        vecs++; if (pass_cnt !== 32'(stats) || drop_cnt !== 32'd0) begin errs++; $display("FAIL midrst_cnt2: got %0d/%0d required %0d/0", pass_cnt, drop_cnt, stats); end
    endtask

    task automatic test_back_to_back();
        bit to; int d, n, p0, d0;
        rmode = 0;
        p0 = exp_pass; d0 = exp_drop;
        send_pkt(12, 1, 0, 8'h00);
        waits = 0;
        send_pkt(9, 0, 0, 8'h00);
        vecs++; if (waits !== 1) begin errs++; $display("FAIL b2b_latency: got %0d stall cycles required 1", waits); end
        drain(to);
        n = act_q.size();
        d = sb_diff();
        vecs++; if (to || n !== 12 || d !== 0) begin errs++; $display("FAIL b2b_egress: got %0d beats %0d diffs required 12/0", n, d); end
        vecs++; if (pass_cnt !== 32'(stats * (p0 + 1)) || drop_cnt !== 32'(stats * (d0 + 1))) begin errs++; $display("FAIL b2b_cnt: got %0d/%0d required %0d/%0d", pass_cnt, drop_cnt, stats * (p0 + 1), stats * (d0 + 1)); end
        vecs++; if (hdr_data !== exp_hdr) begin errs++; $display("FAIL b2b_hdr: got %h required %h", hdr_data, exp_hdr); end
    endtask

    task automatic test_random();
        bit to; int d, n, ne;
        rmode = 1;
        for (int p = 0; p < 30; p++) begin
            send_pkt(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), 2, 8'h00);
            ne = exp_q.size();
            drain(to);
            n = act_q.size();
            d = sb_diff();
            vecs++; if (to || d !== 0) begin errs++; $display("FAIL rand_egress pkt%0d: got %0d beats %0d diffs required %0d/0", p, n, d, ne); end
            vecs++; if (hdr_data !== exp_hdr) begin errs++; $display("FAIL rand_hdr pkt%0d: got %h required %h", p, hdr_data, exp_hdr); end
        end
        rmode = 0;
        vecs++; if (pass_cnt !== 32'(stats * exp_pass) || drop_cnt !== 32'(stats * exp_drop)) begin errs++; $display("FAIL rand_cnt: got %0d/%0d required %0d/%0d", pass_cnt, drop_cnt, stats * exp_pass, stats * exp_drop); end
    endtask

    initial begin
`ifdef PKT_FILTER_CTRL_STATS_EN
        stats = 1;
`endif
        test_reset();
        test_pass_10();
        test_drop_10();
        test_short_3();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
